// File: rtl/ddr_word_tx.sv
// ---------------------------------------------------------------------------
// ddr_word_tx
//   Dual-edge serial word transmitter. A parallel word taken over a
//   valid/ready handshake is shifted out MSB-first on one data line, one bit
//   per clock edge (two bits per cycle). Words can stream back-to-back with
//   no gap; dframe marks the cycles that carry word bits.
//
// Ports
//   clk       system clock, both edges used
//   rst       asynchronous reset, active-low
//   in_data   word to transmit, sampled on an accepting posedge
//   in_valid  in_data is valid
//   in_ready  a word can be accepted at this posedge (state/cnt only)
//   dout      DDR serial data, changes just after either clock edge
//   dframe    high while dout carries word bits, posedge-timed
// ---------------------------------------------------------------------------
module ddr_word_tx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dframe
);

  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] shreg_r;
  logic             p_r;         // posedge half of the XOR pair
  logic             n_r;         // negedge half of the XOR pair
  logic             neg_bit_r;   // bit due on the coming negedge
  logic             dframe_r;
  logic             cnt_last_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             pos_target_s;
  logic             neg_target_s;

  assign cnt_last_s = (cnt_r == CNT_LAST);
  assign accept_s   = in_valid & in_ready_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        // Last bit pair of the word: reload if a word is waiting, else stop.
        if (cnt_last_s && !in_valid) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output logic: ready depends on state and cnt only, never on in_valid
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      SHIFT:   in_ready_s = cnt_last_s;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Bit-pair counter and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r   <= CNT_ZERO;
      shreg_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      cnt_r   <= CNT_ZERO;
      shreg_r <= in_data;
    end else if ((state_r == SHIFT) && !cnt_last_s) begin
      cnt_r   <= cnt_r + CNT_ONE;
      shreg_r <= {shreg_r[WIDTH-3:0], 2'b00};
    end else begin
      cnt_r   <= cnt_r;
      shreg_r <= shreg_r;
    end
  end

  // Bits due this cycle: top pair of the shift register while shifting, else idle low
  always_comb begin
    pos_target_s = 1'b0;
    neg_target_s = 1'b0;
    if (state_r == SHIFT) begin
      pos_target_s = shreg_r[WIDTH-1];
      neg_target_s = shreg_r[WIDTH-2];
    end else begin
      pos_target_s = 1'b0;
      neg_target_s = 1'b0;
    end
  end

  // Posedge half: P is chosen so that P ^ N equals the posedge bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_r       <= 1'b0;
      neg_bit_r <= 1'b0;
      dframe_r  <= 1'b0;
    end else begin
      p_r       <= pos_target_s ^ n_r;
      // Captured here because the shift register moves on at this same edge.
      neg_bit_r <= neg_target_s;
      dframe_r  <= (state_r == SHIFT);
    end
  end

  // Negedge half: N is chosen so that P ^ N equals the negedge bit
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      n_r <= 1'b0;
    end else begin
      n_r <= neg_bit_r ^ p_r;
    end
  end

  assign in_ready = in_ready_s;
  assign dout     = p_r ^ n_r;   // each flop toggles only after its own edge: no glitch
  assign dframe   = dframe_r;

endmodule

// File: tb/tb_ddr_word_tx.sv
// ---------------------------------------------------------------------------
// tb_ddr_word_tx
//   Bench for ddr_word_tx. A queue model holds the bits still owed on the
//   line; every half-cycle dout, dframe and in_ready are compared against it.
//   Directed scenarios add literal expectations on captured frames.
// ---------------------------------------------------------------------------
module tb_ddr_word_tx;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         dout;
  logic         dframe;

  logic [3:0]   in_data4;
  logic         in_valid4;
  logic         in_ready4;
  logic         dout4;
  logic         dframe4;

  int n_pass  = 0;
  int n_total = 0;

  ddr_word_tx #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .dframe   (dframe)
  );

  ddr_word_tx #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data4),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .dout     (dout4),
    .dframe   (dframe4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: queue of bits still owed ----------------
  logic m_q[$];
  logic exp_dout  = 1'b0;
  logic exp_frame = 1'b0;
  logic framing   = 1'b0;
  int   m_pre;

  always @(posedge clk or negedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      framing   = 1'b0;
      exp_dout  = 1'b0;
      exp_frame = 1'b0;
    end else if (clk) begin
      m_pre = m_q.size();
      if (m_pre > 0) begin
        exp_dout  = m_q.pop_front();
        exp_frame = 1'b1;
        framing   = 1'b1;
      end else begin
        exp_dout  = 1'b0;
        exp_frame = 1'b0;
        framing   = 1'b0;
      end
      // Ready when at most the final bit pair of a word is still owed.
      if (in_valid && (m_pre <= 2)) begin
        for (int i = W - 1; i >= 0; i--) m_q.push_back(in_data[i]);
      end
    end else begin
      if (framing && (m_q.size() > 0)) exp_dout = m_q.pop_front();
      else                             exp_dout = 1'b0;
    end
  end

  // ---------------- glitch monitor ----------------
  logic idle_win   = 1'b0;
  int   glitch_cnt = 0;

  always @(dout) begin
    if (idle_win) glitch_cnt++;
  end

  // ---------------- capture of observed line ----------------
  logic cap_q[$];   // in-frame dout half-bits
  logic df_q[$];    // dframe per posedge sample
  logic rdy_q[$];   // in_ready per in-frame cycle
  logic cap_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
  endtask

  task automatic compare_loop();
    forever begin
      @(posedge clk or negedge clk);
      #2;
      if (clk) begin
        check("dout_pos", {31'd0, dout}, {31'd0, exp_dout});
        check("dframe", {31'd0, dframe}, {31'd0, exp_frame});
        df_q.push_back(dframe);
        if (dframe) begin
          cap_q.push_back(dout);
          cap_on = 1'b1;
        end else begin
          cap_on = 1'b0;
        end
      end else begin
        check("dout_neg", {31'd0, dout}, {31'd0, exp_dout});
        check("in_ready", {31'd0, in_ready}, (m_q.size() <= 2) ? 32'd1 : 32'd0);
        if (cap_on) begin
          cap_q.push_back(dout);
          rdy_q.push_back(in_ready);
        end
      end
    end
  endtask

  function automatic logic [31:0] cap_vec(input int s, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = {v[30:0], cap_q[s + i]};
    return v;
  endfunction

  function automatic logic [31:0] rdy_vec(input int s, input int n);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = {v[30:0], rdy_q[s + i]};
    return v;
  endfunction

  function automatic int df_ones(input int s);
    int c;
    c = 0;
    for (int i = s; i < df_q.size(); i++) if (df_q[i]) c++;
    return c;
  endfunction

  function automatic int df_run(input int s);
    int r;
    int m;
    r = 0;
    m = 0;
    for (int i = s; i < df_q.size(); i++) begin
      if (df_q[i]) begin
        r++;
        if (r > m) m = r;
      end else begin
        r = 0;
      end
    end
    return m;
  endfunction

  // One input cycle: drive at negedge, sampled by the following posedge.
  task automatic cyc(input logic v, input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
  endtask

  int s_cap;
  int s_df;
  int s_rdy;
  logic [0:2] w4_hi;
  logic [0:2] w4_lo;
  logic [0:2] w4_fr;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    in_valid4 = 1'b0;
    in_data4  = 4'h0;
    w4_hi     = 3'b110;
    w4_lo     = 3'b010;
    w4_fr     = 3'b110;

    fork
      compare_loop();
    join_none

    // Reset state
    #7;
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_dframe", {31'd0, dframe}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_in_ready4", {31'd0, in_ready4}, 32'd1);
    #6;
    rst = 1'b1;

    // Single word, one-cycle valid
    s_cap = cap_q.size();
    s_df  = df_q.size();
    cyc(1'b1, 16'hA5C3);
    repeat (12) cyc(1'b0, 16'h0000);
    check("sw_nbits", cap_q.size() - s_cap, 32'd16);
    check("sw_bits", cap_vec(s_cap, 16), 32'h0000A5C3);
    check("sw_frame_cycles", df_ones(s_df), 32'd8);
    check("sw_frame_run", df_run(s_df), 32'd8);

    // Back-to-back: FFFF then 0000 held until taken
    s_cap = cap_q.size();
    s_df  = df_q.size();
    s_rdy = rdy_q.size();
    cyc(1'b1, 16'hFFFF);
    repeat (8) cyc(1'b1, 16'h0000);
    repeat (12) cyc(1'b0, 16'h0000);
    check("b2b_nbits", cap_q.size() - s_cap, 32'd32);
    check("b2b_bits", cap_vec(s_cap, 32), 32'hFFFF0000);
    check("b2b_frame_cycles", df_ones(s_df), 32'd16);
    check("b2b_frame_run", df_run(s_df), 32'd16);
    check("b2b_ready_nsamp", rdy_q.size() - s_rdy, 32'd16);
    // high at cnt=7 of each word, plus the idle tail cycle of the last word
    check("b2b_ready_pattern", rdy_vec(s_rdy, 16), 32'h00000203);

    // Backpressure: 8001 presented while 1234 is in flight
    s_cap = cap_q.size();
    s_df  = df_q.size();
    cyc(1'b1, 16'h1234);
    repeat (8) cyc(1'b1, 16'h8001);
    repeat (12) cyc(1'b0, 16'h0000);
    check("bp_nbits", cap_q.size() - s_cap, 32'd32);
    check("bp_bits", cap_vec(s_cap, 32), 32'h12348001);
    check("bp_frame_run", df_run(s_df), 32'd16);

    // Reset mid-word, asserted and released in the clk-low phase
    cyc(1'b1, 16'hFFFF);
    repeat (5) cyc(1'b0, 16'h0000);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_dout", {31'd0, dout}, 32'd0);
    check("mid_rst_dframe", {31'd0, dframe}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    s_cap    = cap_q.size();
    s_df     = df_q.size();
    in_valid = 1'b1;
    in_data  = 16'h00FF;
    rst      = 1'b1;
    repeat (12) cyc(1'b0, 16'h0000);
    check("post_rst_nbits", cap_q.size() - s_cap, 32'd16);
    check("post_rst_bits", cap_vec(s_cap, 16), 32'h000000FF);
    check("post_rst_frame_cycles", df_ones(s_df), 32'd8);

    // Idle with no valid, in_data wandering
    s_df     = df_q.size();
    idle_win = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b0, 16'(i * 4369));
    idle_win = 1'b0;
    check("idle_glitches", glitch_cnt, 32'd0);
    check("idle_frame_cycles", df_ones(s_df), 32'd0);

    // WIDTH=4 instance, word 0xB
    @(negedge clk);
    in_valid4 = 1'b1;
    in_data4  = 4'hB;
    @(negedge clk);
    in_valid4 = 1'b0;
    in_data4  = 4'h0;
    #2;
    check("w4_busy_ready", {31'd0, in_ready4}, 32'd0);
    check("w4_dout_pre", {31'd0, dout4}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check("w4_dout_pos", {31'd0, dout4}, {31'd0, w4_hi[i]});
      check("w4_dframe", {31'd0, dframe4}, {31'd0, w4_fr[i]});
      @(negedge clk);
      #2;
      check("w4_dout_neg", {31'd0, dout4}, {31'd0, w4_lo[i]});
      check("w4_ready", {31'd0, in_ready4}, 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
